// File: rtl/fp_divider.sv
// Single-precision floating-point divider: special-case shortcut, 26-cycle
// radix-2 restoring significand division, then one rounding cycle.
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  round_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] resultDiv,
    output logic        errorDiv,
    output logic        overflowDiv
);

    typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, ROUND} state_t;

    state_t             state_q, state_d;
    logic        [31:0] a_q, a_d, b_q, b_d;
    logic        [1:0]  mode_q, mode_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic        [23:0] divisor_q, divisor_d;
    logic        [24:0] rem_q, rem_d;
    logic        [25:0] quot_q, quot_d;
    logic        [4:0]  count_q, count_d;
    logic               done_q, done_d;
    logic        [31:0] result_q, result_d;
    logic               error_q, error_d;
    logic               overflow_q, overflow_d;

    logic               specialIn, preShift;
    logic        [23:0] mantA, mantB, trial;
    logic signed [9:0]  expIn;
    logic        [24:0] remIn;
    logic               aNaN, bNaN, aInf, bInf, aZero, bZero;
    logic        [31:0] specResult;
    logic               specError;
    logic               inexact, roundUp, toInf;
    logic        [24:0] sigRounded;
    logic        [22:0] mantOut;
    logic signed [9:0]  expRounded;
    logic        [31:0] roundResult;
    logic               roundOvf;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign resultDiv   = result_q;
    assign errorDiv    = error_q;
    assign overflowDiv = overflow_q;

    // Decode live inputs at acceptance: special detection, pre-shift and initial exponent
    always_comb begin
        specialIn = (A[30:23] == 8'h00) || (A[30:23] == 8'hFF) ||
                    (B[30:23] == 8'h00) || (B[30:23] == 8'hFF);
        mantA     = {1'b1, A[22:0]};
        mantB     = {1'b1, B[22:0]};
        preShift  = (mantA < mantB);
        expIn     = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127
                    - (preShift ? 10'sd1 : 10'sd0);
        remIn     = preShift ? {mantA, 1'b0} : {1'b0, mantA};
    end

    // Special-operand result from the latched operands, in priority order
    always_comb begin
        aNaN  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        bNaN  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        aInf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        bInf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        aZero = (a_q[30:23] == 8'h00);
        bZero = (b_q[30:23] == 8'h00);
        specError  = 1'b0;
        specResult = {sign_q, 31'd0};
        if (aNaN || bNaN || (aZero && bZero) || (aInf && bInf)) begin
            specResult = 32'h7FC00000;
            specError  = 1'b1;
        end else if (bZero && !aInf) begin
            specResult = {sign_q, 8'hFF, 23'd0};
            specError  = 1'b1;
        end else if (aInf) begin
            specResult = {sign_q, 8'hFF, 23'd0};
        end
    end

    // Rounding of the 24-bit quotient with guard, round and sticky, then range check
    always_comb begin
        inexact = quot_q[1] || quot_q[0] || (rem_q != 25'd0);
        case (mode_q)
            2'b00:   roundUp = !sign_q && inexact;
            2'b01:   roundUp = sign_q && inexact;
            2'b10:   roundUp = quot_q[1] && (quot_q[0] || (rem_q != 25'd0) || quot_q[2]);
            default: roundUp = 1'b0;
        endcase
        toInf      = (mode_q == 2'b10) || (mode_q == 2'b00 && !sign_q) ||
                     (mode_q == 2'b01 && sign_q);
        sigRounded = {1'b0, quot_q[25:2]} + {24'd0, roundUp};
        mantOut    = sigRounded[24] ? sigRounded[23:1] : sigRounded[22:0];
        expRounded = exp_q + (sigRounded[24] ? 10'sd1 : 10'sd0);
        roundOvf   = 1'b0;
        if (expRounded >= 10'sd255) begin
            roundOvf    = 1'b1;
            roundResult = toInf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'h7F7FFFFF};
        end else if (expRounded <= 10'sd0) begin
            roundResult = {sign_q, 31'd0};
        end else begin
            roundResult = {sign_q, expRounded[7:0], mantOut};
        end
    end

    // Next-state and datapath updates; result registers change only with done
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        count_d    = count_q;
        done_d     = 1'b0;
        result_d   = result_q;
        error_d    = error_q;
        overflow_d = overflow_q;
        trial      = rem_q[23:0] - divisor_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    mode_d    = round_mode;
                    sign_d    = A[31] ^ B[31];
                    exp_d     = expIn;
                    divisor_d = mantB;
                    rem_d     = remIn;
                    quot_d    = 26'd0;
                    count_d   = 5'd0;
                    state_d   = specialIn ? SPECIAL : DIVIDE;
                end
            end
            SPECIAL: begin
                result_d   = specResult;
                error_d    = specError;
                overflow_d = 1'b0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            DIVIDE: begin
                if (rem_q >= {1'b0, divisor_q}) begin
                    quot_d = {quot_q[24:0], 1'b1};
                    rem_d  = {trial, 1'b0};
                end else begin
                    quot_d = {quot_q[24:0], 1'b0};
                    rem_d  = {rem_q[23:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd25) begin
                    count_d = 5'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d   = roundResult;
                error_d    = roundOvf;
                overflow_d = roundOvf;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            mode_q     <= 2'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            divisor_q  <= 24'd0;
            rem_q      <= 25'd0;
            quot_q     <= 26'd0;
            count_q    <= 5'd0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            count_q    <= count_d;
            done_q     <= done_d;
            result_q   <= result_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low: clk (rising edge) and rst_n.
REQ-002 Ports, one per line, SHALL be:
  clk  input  1  clock
  rst_n  input  1  async active-low reset
  start  input  1  request; sampled only in IDLE
  A  input  32  IEEE-754 single dividend
  B  input  32  IEEE-754 single divisor
  round_mode  input  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 toward zero
  busy  output  1  high from start acceptance until done
  done  output  1  one-cycle pulse; result and flags valid
  resultDiv  output  32  quotient A/B
  errorDiv  output  1  invalid, divide-by-zero or overflow
  overflowDiv  output  1  exponent overflow

Function
REQ-003 A, B and round_mode SHALL be latched on the edge accepting start; later input changes SHALL have no effect on the operation in progress.
REQ-004 The FSM SHALL have states IDLE, SPECIAL, DIVIDE, ROUND: IDLE->SPECIAL on start with a special operand, IDLE->DIVIDE otherwise; SPECIAL->IDLE after 1 cycle; DIVIDE->ROUND after 26 iterations; ROUND->IDLE after 1 cycle.
REQ-005 If start is accepted at edge N, done SHALL be high in the cycle after edge N+1 for special operands and after edge N+27 for normal operands; busy SHALL be high from edge N until the edge that raises done.
REQ-006 start SHALL be ignored while busy is high.
REQ-007 resultDiv, errorDiv and overflowDiv SHALL update only on the edge that raises done, and hold until the next done.
REQ-008 Inputs with exponent 0 SHALL be treated as signed zero (subnormals flushed); sign SHALL be A[31] xor B[31] for every non-NaN result.
REQ-009 Special cases, in priority order:
  - NaN operand, 0/0 or inf/inf -> 0x7FC00000, errorDiv=1, overflowDiv=0.
  - Finite nonzero/0 -> signed inf, errorDiv=1, overflowDiv=0.
  - inf/finite -> signed inf, flags 0.
  - 0/nonzero or finite/inf -> signed zero, flags 0.
REQ-010 Normal path: mantissas {1,F}; exponent = E1-E2+127 in 10-bit signed; if M1<M2, the dividend SHALL be pre-shifted left 1 and the exponent decremented.
REQ-011 DIVIDE SHALL perform a radix-2 restoring division producing one quotient bit per cycle: 24 significand bits, then guard and round bits; sticky = nonzero final remainder.
REQ-012 ROUND SHALL apply round_mode using guard, round and sticky bits: RNE ties to even; directed modes increment only on a nonzero remainder toward the matching sign; RTZ truncates.
REQ-013 A rounding carry-out SHALL shift the significand right 1 and increment the exponent.
REQ-014 Exponent >= 255 SHALL set overflowDiv=1 and errorDiv=1. The result SHALL be signed inf under RNE and under the directed mode toward the sign; otherwise it SHALL be signed 0x7F7FFFFF.
REQ-015 Exponent <= 0 SHALL give signed zero with flags 0.

Reset
REQ-016 While rst_n is low: state IDLE, busy=0, done=0, resultDiv=0x00000000, errorDiv=0, overflowDiv=0, iteration counter 0.
REQ-017 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-018 The bench SHALL cover these scenarios:
  - 0x40C00000/0x40000000, RNE -> 0x40400000, flags 0, done exactly 27 cycles after start, busy high 27 cycles.
  - 0x3F800000/0x40400000 -> RNE 0x3EAAAAAB, RTZ 0x3EAAAAAA, +inf 0x3EAAAAAB, -inf 0x3EAAAAAA.
  - 0xBF800000/0x40400000, mode 01 -> 0xBEAAAAAB.
  - 0x3F800000/0x00000000 -> 0x7F800000, errorDiv=1, overflowDiv=0, done 1 cycle after start.
  - 0x00000000/0x00000000 -> 0x7FC00000, errorDiv=1.
  - 0x7F000000/0x3E800000 -> RNE 0x7F800000 and RTZ 0x7F7FFFFF, both with overflowDiv=1 and errorDiv=1.
  - 0x00800000/0x40000000 -> 0x00000000, flags 0.
  - start again at cycle 5 of a division -> ignored, first result unchanged.
  - rst_n low at cycle 10 -> busy=0, no done pulse, resultDiv=0.
  - A new start after reset -> completes normally.
